// File: rtl/async_wr_addr_cac_if.sv
// async_wr_addr_cac_if: write-side FIFO pointer bus between the write logic and its user / read domain.
interface async_wr_addr_cac_if #(parameter int ADDR_SIZE = 4);
  logic                 wr_en;
  logic                 ovf_clr;
  logic [ADDR_SIZE:0]   rd_addr_gray;
  logic [ADDR_SIZE:0]   wr_addr_gray;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic                 wr_vld;
  logic                 full;
  logic                 overflow;
  logic                 almost_full;
  logic [ADDR_SIZE:0]   wr_level;
  modport master (output wr_en, ovf_clr, rd_addr_gray,
                  input  wr_addr_gray, wr_addr, wr_vld, full, overflow, almost_full, wr_level);
  modport slave  (input  wr_en, ovf_clr, rd_addr_gray,
                  output wr_addr_gray, wr_addr, wr_vld, full, overflow, almost_full, wr_level);
endinterface

// File: rtl/async_wr_addr_cac.sv
// async_wr_addr_cac: dual-clock FIFO write pointer, registered pessimistic full and sticky overflow.
// Define ASYNC_WR_ALMOST_FULL_EN to elaborate wr_level / almost_full; otherwise both are tied to 0.
module async_wr_addr_cac #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_THRESH = 12
) (
  input logic                 wr_clk,
  input logic                 wr_rst,
  async_wr_addr_cac_if.slave  bus
);
  logic [ADDR_SIZE:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
  logic [ADDR_SIZE:0] rd_sync1_q, rd_sync2_q, lvl_q, lvl_d;
  logic               full_q, full_d, ovf_q, ovf_d, af_q, af_d, wr_vld;
  always_comb begin
    wr_vld    = bus.wr_en & ~full_q;
    wr_bin_d  = wr_bin_q + {{ADDR_SIZE{1'b0}}, wr_vld};
    wr_gray_d = (wr_bin_d >> 1) ^ wr_bin_d;
    // full compares the next pointer, so the filling write itself raises it
    full_d    = wr_gray_d == {~rd_sync2_q[ADDR_SIZE:ADDR_SIZE-1], rd_sync2_q[ADDR_SIZE-2:0]};
    ovf_d     = (bus.wr_en & full_q) | (ovf_q & ~bus.ovf_clr);
  end
`ifdef ASYNC_WR_ALMOST_FULL_EN
  localparam logic [ADDR_SIZE:0] AF_T = AF_THRESH[ADDR_SIZE:0];
  logic [ADDR_SIZE:0] rd_bin;
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) rd_bin[i] = ^(rd_sync2_q >> i);
    lvl_d = wr_bin_d - rd_bin;
    af_d  = lvl_d >= AF_T;
  end
`else
  always_comb begin
    lvl_d = '0;
    af_d  = 1'b0;
  end
`endif
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      rd_sync1_q <= '0;
      rd_sync2_q <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      lvl_q      <= '0;
      af_q       <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      rd_sync1_q <= bus.rd_addr_gray;
      rd_sync2_q <= rd_sync1_q;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      lvl_q      <= lvl_d;
      af_q       <= af_d;
    end
  end
  assign bus.wr_vld       = wr_vld;
  assign bus.wr_addr_gray = wr_gray_q;
  assign bus.wr_addr      = wr_bin_q[ADDR_SIZE-1:0];
  assign bus.full         = full_q;
  assign bus.overflow     = ovf_q;
  assign bus.almost_full  = af_q;
  assign bus.wr_level     = lvl_q;
endmodule

// File: tb/tb_async_wr_addr_cac.sv
// tb_async_wr_addr_cac: directed checks of reset, fill, overflow, full release, wrap and level.
module tb_async_wr_addr_cac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  async_wr_addr_cac_if #(.ADDR_SIZE(4)) bus ();
  async_wr_addr_cac #(.ADDR_SIZE(4), .AF_THRESH(12)) dut (.wr_clk(clk), .wr_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_gray"}, 32'(bus.wr_addr_gray), 0);
    chk({tag, "_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_vld"}, 32'(bus.wr_vld), 0);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    chk({tag, "_af"}, 32'(bus.almost_full), 0);
    chk({tag, "_lvl"}, 32'(bus.wr_level), 0);
  endtask
  initial begin
    logic [4:0] n;
    logic [4:0] exp_lvl;
    logic       exp_af;
    bus.wr_en = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.rd_addr_gray = '0;
    #12;
    chk_zero("rst_init");
    rst = 1'b0;
    // reset mid-stream
    step();
    bus.wr_en = 1'b1;
    repeat (5) step();
    chk("pre_rst_gray", 32'(bus.wr_addr_gray), 32'h07);
    chk("pre_rst_addr", 32'(bus.wr_addr), 5);
    bus.wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    step();
    rst = 1'b0;
    // fill
    bus.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 chk("fill_vld", 32'(bus.wr_vld), 1);
      chk("fill_full_low", 32'(bus.full), 0);
      step();
    end
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_gray", 32'(bus.wr_addr_gray), 32'h18);
    chk("fill_addr", 32'(bus.wr_addr), 0);
    // overflow
    chk("ovf_vld", 32'(bus.wr_vld), 0);
    step();
    chk("ovf_gray", 32'(bus.wr_addr_gray), 32'h18);
    chk("ovf_set", 32'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", 32'(bus.overflow), 1);
    bus.wr_en = 1'b0;
    step();
    chk("ovf_clr", 32'(bus.overflow), 0);
    bus.ovf_clr = 1'b0;
    // release
    bus.rd_addr_gray = 5'b00001;
    step();
    chk("rel_e1", 32'(bus.full), 1);
    step();
    chk("rel_e2", 32'(bus.full), 1);
    step();
    chk("rel_e3", 32'(bus.full), 0);
    bus.wr_en = 1'b1;
    #1 chk("rel_vld", 32'(bus.wr_vld), 1);
    step();
    bus.wr_en = 1'b0;
    chk("refull", 32'(bus.full), 1);
    chk("refull_gray", 32'(bus.wr_addr_gray), 32'h19);
    // wrap with tracking read side
    rst = 1'b1;
    #1 rst = 1'b0;
    bus.rd_addr_gray = '0;
    bus.wr_en = 1'b1;
    n = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      n = n + 5'd1;
      bus.rd_addr_gray = gray(n);
      chk("wrap_gray", 32'(bus.wr_addr_gray), 32'(gray(n)));
      chk("wrap_full", 32'(bus.full), 0);
    end
    chk("wrap_ptr", 32'(bus.wr_addr), 32'(n[3:0]));
    chk("wrap_ovf", 32'(bus.overflow), 0);
    bus.wr_en = 1'b0;
    // level
    rst = 1'b1;
    #1 rst = 1'b0;
    bus.rd_addr_gray = '0;
    bus.wr_en = 1'b1;
    repeat (11) step();
`ifdef ASYNC_WR_ALMOST_FULL_EN
    exp_lvl = 5'd11;
`else
    exp_lvl = 5'd0;
`endif
    chk("lvl11", 32'(bus.wr_level), 32'(exp_lvl));
    chk("af11", 32'(bus.almost_full), 0);
    step();
`ifdef ASYNC_WR_ALMOST_FULL_EN
    exp_lvl = 5'd12;
    exp_af = 1'b1;
`else
    exp_lvl = 5'd0;
    exp_af = 1'b0;
`endif
    chk("lvl12", 32'(bus.wr_level), 32'(exp_lvl));
    chk("af12", 32'(bus.almost_full), 32'(exp_af));
    bus.wr_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
